scrub_rate_monitor: RTL
=======================

# scrub_rate_monitor

Multi-channel bit-flip rate monitor for scrubbed memories. Each channel watches a vector of scrub-error flags and measures the interval in cycles between bit-flip events. It keeps a shift-based exponential moving average (EMA) of that interval and raises a maskable, sticky interrupt when the average falls below a programmable threshold. It sits beside the scrubbers and is read and configured by software over a single-cycle register request/response port.

## Interface
Parameters:
- NUM_CH, 4: number of monitored channels (1..8).
- SCRUB_WIDTH, 32: scrub flag bits per channel.
- CNT_WIDTH, 32: width of interval counter, average, event count and threshold (≤ DATA_WIDTH).
- EMA_SHIFT, 3: EMA weight is 2^-EMA_SHIFT (1..8).
- ADDR_WIDTH, 4: register word address width.
- DATA_WIDTH, 32: register data width.

Ports:
- clk_i, in, 1: the single clock.
- rst_i, in, 1: reset; asynchronous, active-high.
- scrub_i, in, NUM_CH*SCRUB_WIDTH: flag bits; channel c occupies bits [c*SCRUB_WIDTH +: SCRUB_WIDTH].
- req_valid_i, in, 1: register request strobe.
- req_write_i, in, 1: 1 = write, 0 = read.
- req_addr_i, in, ADDR_WIDTH: word address.
- req_wdata_i, in, DATA_WIDTH: write data.
- rsp_ready_o, out, 1: one-cycle pulse; request completed.
- rsp_error_o, out, 1: one-cycle pulse; request rejected.
- rsp_rdata_o, out, DATA_WIDTH: read data; holds its value until the next read.
- irq_o, out, 1: OR of (IRQ_STATUS & IRQ_EN).

## Operation
- scrub_i is registered once. The channel event flag is the OR of the registered channel bits. Multiple set bits in one cycle count as a single event.
- Per-channel FSM; it advances only while CTRL.EN = 1. When EN = 0, all channel state, counters and averages are frozen.
  - IDLE: no event yet. On an event: interval counter ← 0, go to ARMED.
  - ARMED: the counter increments on each cycle without an event. On an event: sample = counter+1, AVG ← sample, counter ← 0, go to TRACKING.
  - TRACKING: counting is the same as ARMED. On an event: AVG ← AVG − (AVG >> EMA_SHIFT) + (sample >> EMA_SHIFT), truncating.
- Interval counter and sample saturate at 2^CNT_WIDTH−1.
- Event count increments on every event in any state and saturates.
- Alarm: in TRACKING, when AVG < THRESHOLD, set IRQ_STATUS[c]. Status is sticky; it is set regardless of IRQ_EN.
- Soft clear (CTRL.CLR write 1; self-clearing): all channels go to IDLE; counters, AVG and event counts are zeroed. IRQ_STATUS is untouched.
- Register map (word addresses):
  - 0x0 CTRL, RW: bit0 EN, bit1 CLR (always reads 0).
  - 0x1 IRQ_EN, RW: bits [NUM_CH-1:0].
  - 0x2 IRQ_STATUS, RO/W1C.
  - 0x3 THRESHOLD, RW.
  - 0x4+c AVG[c], RO.
  - 0x4+NUM_CH+c EVCNT[c], RO.
  - Unused upper bits read as 0.
- Errors: an address above the last EVCNT, or a write to an RO register, gives rsp_error_o = 1 and rsp_ready_o = 0. On an error read, rsp_rdata_o = 0xDEADBEEF. An error write has no side effect.

## Timing
- Reset values: rsp_ready_o = 0, rsp_error_o = 0, rsp_rdata_o = 0, irq_o = 0. CTRL = 0, IRQ_EN = 0, IRQ_STATUS = 0, THRESHOLD = 0, all channels IDLE, all counters 0.
- Register access: the request is sampled at edge E. The response (ready or error, plus rdata) is valid in the cycle after E for exactly one cycle. A write takes effect at E. A new request is accepted every cycle.
- Event latency: scrub bit high before edge E0 → registered at E0 → channel update at E1 → IRQ_STATUS set at E2 → irq_o high after E2.
- Flags on consecutive sampled cycles give sample = 1.
- Simultaneous events:
  - Soft clear and event in the same cycle: the clear wins and the event is dropped.
  - W1C and a new alarm set in the same cycle: the set wins.
  - EN written 0 and an event in the same cycle: the event is dropped.
- A reset asserted mid-operation returns every register to its reset value immediately, without waiting for a clock edge.

## Test plan
- Reset, then read 0x0..0x3 → each returns 0 with ready. Read 0xF (NUM_CH = 4) → error, rdata 0xDEADBEEF. Write 0x4 → error, AVG unchanged.
- EN = 1; channel 0 flags at sampled cycles 0, 10, 20, 30 → AVG[0] = 10 throughout, EVCNT[0] = 4, no status set.
- Continue with THRESHOLD = 8, IRQ_EN = 1, then channel 0 intervals of 2 → AVG goes 9, 8, 7. IRQ_STATUS[0] sets on the third short interval and irq_o rises 2 cycles after that flag is sampled. W1C 0x2 = 1 → irq_o drops.
- Channel 1 alarm with IRQ_EN[1] = 0 → IRQ_STATUS[1] = 1 and irq_o = 0. Then set IRQ_EN[1] = 1 → irq_o = 1 on the next cycle.
- Soft clear while channel 2 has an event in the same cycle → AVG[2] = 0, EVCNT[2] = 0, channel back in IDLE. The next two events 5 cycles apart give AVG[2] = 5.
- Assert rst_i between two events → all outputs and registers return to 0. After reset, the first event only arms the channel (AVG stays 0).

Source files
------------

// File: rtl/scrub_rate_monitor_if.sv
// Register request/response port of scrub_rate_monitor.
// Requests are single-cycle; responses pulse one cycle later.
interface scrub_rate_monitor_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid_i;
  logic                  req_write_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  rsp_ready_o;
  logic                  rsp_error_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;

  modport master (
    output req_valid_i, req_write_i,
    output req_addr_i, req_wdata_i,
    input  rsp_ready_o, rsp_error_o,
    input  rsp_rdata_o
  );

  modport slave (
    input  req_valid_i, req_write_i,
    input  req_addr_i, req_wdata_i,
    output rsp_ready_o, rsp_error_o,
    output rsp_rdata_o
  );
endinterface

// File: rtl/scrub_rate_monitor.sv
// Per-channel bit-flip interval EMA monitor with
// sticky maskable alarm and a register port.
module scrub_rate_monitor #(
  parameter int NUM_CH      = 4,
  parameter int SCRUB_WIDTH = 32,
  parameter int CNT_WIDTH   = 32,
  parameter int EMA_SHIFT   = 3,
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_CH*SCRUB_WIDTH-1:0] scrub_i,
  scrub_rate_monitor_if.slave           bus,
  output logic                          irq_o
);
  typedef enum logic [1:0] {
    IDLE, ARMED, TRACKING
  } ch_state_e;

  localparam logic [31:0] LAST = 32'(3 + 2 * NUM_CH);
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;
  localparam logic [DATA_WIDTH-1:0] ERR_DATA =
    DATA_WIDTH'(32'hDEADBEEF);

  logic [NUM_CH*SCRUB_WIDTH-1:0] scrub_q;
  logic [NUM_CH-1:0]    ev;
  ch_state_e            state_q [NUM_CH];
  ch_state_e            state_d [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CH];
  logic [CNT_WIDTH-1:0] avg_q [NUM_CH];
  logic [CNT_WIDTH-1:0] avg_d [NUM_CH];
  logic [CNT_WIDTH-1:0] evc_q [NUM_CH];
  logic [CNT_WIDTH-1:0] evc_d [NUM_CH];
  logic [CNT_WIDTH-1:0] smp   [NUM_CH];
  logic [NUM_CH-1:0]    chk_q, chk_d;
  logic [NUM_CH-1:0]    set, w1c;
  logic [NUM_CH-1:0]    irq_en_q, irq_en_d;
  logic [NUM_CH-1:0]    status_q, status_d;
  logic [CNT_WIDTH-1:0] thr_q, thr_d;
  logic                 en_q, en_d;
  logic                 rsp_ready_q, rsp_ready_d;
  logic                 rsp_error_q, rsp_error_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [ADDR_WIDTH-1:0] addr_n;
  logic [31:0]           addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic is_rd, is_wr, bad, wr_ok, clr;

  assign addr_n = bus.req_addr_i;
  assign addr   = 32'(addr_n);
  assign wdata  = bus.req_wdata_i;
  assign is_wr  = bus.req_valid_i & bus.req_write_i;
  assign is_rd  = bus.req_valid_i & ~bus.req_write_i;
  assign bad    = (addr > LAST) |
                  (bus.req_write_i & (addr >= 32'd4));
  assign wr_ok  = is_wr & ~bad;

  always_comb begin
    ev = '0;
    for (int c = 0; c < NUM_CH; c++)
      ev[c] = |scrub_q[c*SCRUB_WIDTH +: SCRUB_WIDTH];
  end

  // Writes take effect at the sampling edge, so the
  // channel update below sees the new EN/CLR.
  always_comb begin
    en_d     = en_q;
    clr      = 1'b0;
    irq_en_d = irq_en_q;
    thr_d    = thr_q;
    w1c      = '0;
    if (wr_ok) begin
      case (addr)
        32'd0: begin
          en_d = wdata[0];
          clr  = wdata[1];
        end
        32'd1: irq_en_d = wdata[NUM_CH-1:0];
        32'd2: w1c      = wdata[NUM_CH-1:0];
        32'd3: thr_d    = wdata[CNT_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rsp_ready_d = bus.req_valid_i & ~bad;
    rsp_error_d = bus.req_valid_i & bad;
    rdata_d     = rdata_q;
    if (is_rd) begin
      rdata_d = '0;
      if (bad) begin
        rdata_d = ERR_DATA;
      end else begin
        case (addr)
          32'd0: rdata_d[0] = en_q;
          32'd1: rdata_d[NUM_CH-1:0] = irq_en_q;
          32'd2: rdata_d[NUM_CH-1:0] = status_q;
          32'd3: rdata_d[CNT_WIDTH-1:0] = thr_q;
          default: ;
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
          if (addr == 32'(4 + c))
            rdata_d[CNT_WIDTH-1:0] = avg_q[c];
          if (addr == 32'(4 + NUM_CH + c))
            rdata_d[CNT_WIDTH-1:0] = evc_q[c];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    avg_d   = avg_q;
    evc_d   = evc_q;
    chk_d   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      smp[c] = (cnt_q[c] == CMAX) ? CMAX
                                  : cnt_q[c] + 1'b1;
      if (clr) begin
        state_d[c] = IDLE;
        cnt_d[c]   = '0;
        avg_d[c]   = '0;
        evc_d[c]   = '0;
      end else if (en_d) begin
        if (ev[c]) begin
          cnt_d[c] = '0;
          if (evc_q[c] != CMAX)
            evc_d[c] = evc_q[c] + 1'b1;
          unique case (state_q[c])
            IDLE: state_d[c] = ARMED;
            ARMED: begin
              avg_d[c]   = smp[c];
              state_d[c] = TRACKING;
              chk_d[c]   = 1'b1;
            end
            TRACKING: begin
              avg_d[c] = avg_q[c]
                       - (avg_q[c] >> EMA_SHIFT)
                       + (smp[c] >> EMA_SHIFT);
              chk_d[c] = 1'b1;
            end
            default: state_d[c] = IDLE;
          endcase
        end else if (state_q[c] != IDLE &&
                     cnt_q[c] != CMAX) begin
          cnt_d[c] = cnt_q[c] + 1'b1;
        end
      end
    end
  end

  // Alarm is judged once per freshly updated average.
  always_comb begin
    set = '0;
    for (int c = 0; c < NUM_CH; c++)
      set[c] = chk_q[c] & (avg_q[c] < thr_q);
    status_d = (status_q & ~w1c) | set;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scrub_q     <= '0;
      en_q        <= 1'b0;
      irq_en_q    <= '0;
      status_q    <= '0;
      thr_q       <= '0;
      chk_q       <= '0;
      rsp_ready_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rdata_q     <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= IDLE;
        cnt_q[c]   <= '0;
        avg_q[c]   <= '0;
        evc_q[c]   <= '0;
      end
    end else begin
      scrub_q     <= scrub_i;
      en_q        <= en_d;
      irq_en_q    <= irq_en_d;
      status_q    <= status_d;
      thr_q       <= thr_d;
      chk_q       <= chk_d;
      rsp_ready_q <= rsp_ready_d;
      rsp_error_q <= rsp_error_d;
      rdata_q     <= rdata_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      avg_q       <= avg_d;
      evc_q       <= evc_d;
    end
  end

  assign bus.rsp_ready_o = rsp_ready_q;
  assign bus.rsp_error_o = rsp_error_q;
  assign bus.rsp_rdata_o = rdata_q;
  assign irq_o = |(status_q & irq_en_q);
endmodule
